// File: rtl/mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported memory bus.
// Stalls the pipeline until every access requested this pipeline cycle has completed.
module mem_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    input  logic        dm_ce,
    input  logic        dm_we,
    input  logic [3:0]  dm_sel,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        stallreq,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    // state  | meaning
    // IDLE   | no access on the bus; pick the next outstanding port (data first)
    // BUSY_D | data access on the bus, waiting for mem_ack or timeout
    // BUSY_I | fetch access on the bus, waiting for mem_ack or timeout
    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic       done_i, done_d;
    logic [7:0] wait_cnt;
    logic       need_i, need_d;
    logic       busy, timed_out, finish;

    assign need_d    = dm_ce & ~done_d;
    assign need_i    = if_ce & ~done_i;
    // Reset forces the stall low even though the cleared done flags would raise it.
    assign stallreq  = rst & (need_d | need_i);
    assign busy      = (state == BUSY_D) || (state == BUSY_I);
    assign timed_out = busy & ~mem_ack & (wait_cnt == WAIT_LAST);
    assign finish    = busy & (mem_ack | timed_out);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (need_d)      state_nx = BUSY_D;
                else if (need_i) state_nx = BUSY_I;
            end
            BUSY_D, BUSY_I: begin
                if (finish) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= 4'b0000;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            bus_err   <= 1'b0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
            wait_cnt  <= 8'd0;
        end else begin
            bus_err <= timed_out;
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (need_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_sel   <= dm_sel;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (need_i) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_sel  <= 4'b1111;
                        mem_addr <= if_addr;
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (finish) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= 8'd0;
                        if (!mem_we) begin
                            if (state == BUSY_D) dm_rdata <= mem_ack ? mem_rdata : ERR_DATA;
                            else                 if_rdata <= mem_ack ? mem_rdata : ERR_DATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: wait_cnt <= 8'd0;
            endcase
        end
    end

    // The release edge (stallreq low) clears both flags; a completion on the same edge wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_i <= 1'b0;
            done_d <= 1'b0;
        end else begin
            if (!stallreq) begin
                done_i <= 1'b0;
                done_d <= 1'b0;
            end
            if (finish && state == BUSY_D) done_d <= 1'b1;
            if (finish && state == BUSY_I) done_i <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized pipeline cycles
// against a transaction-level model of stall length, bus accesses and returned data.
module tb_mem_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce, dm_ce, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_sel;
    logic [31:0] if_rdata, dm_rdata;
    logic        stallreq, mem_req, mem_we, bus_err;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata),
        .dm_ce(dm_ce), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .stallreq(stallreq),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } acc_t;

    acc_t        obs_q[$];
    int          dly_q[$];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          checks = 0, errors = 0;
    int          bus_err_cnt = 0, hold_errs = 0;
    logic [31:0] exp_if = 32'd0, exp_dm = 32'd0;

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_bus(logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_ref(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory slave: acks after the queued number of wait cycles, checks mem_* stay held.
    bit   active = 0;
    int   rcnt = 0, rdly = 0;
    acc_t cur;
    always @(negedge clk) begin
        if (bus_err === 1'b1) bus_err_cnt++;
        if (rst && mem_req) begin
            if (!active) begin
                active = 1;
                rcnt   = 0;
                rdly   = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                cur    = '{mem_addr, mem_we, mem_sel, mem_wdata};
                obs_q.push_back(cur);
            end else if (mem_addr !== cur.addr || mem_we !== cur.we ||
                         mem_sel !== cur.sel || mem_wdata !== cur.wdata) begin
                hold_errs++;
            end
            if (rcnt == rdly) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    bus_mem[mem_addr] = merge(rd_bus(mem_addr), mem_wdata, mem_sel);
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = rd_bus(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            rcnt++;
        end else begin
            active  = 0;
            mem_ack = 1'b0;
        end
    end

    // One pipeline cycle: present requests, wait for release, compare against the model.
    task automatic run_txn(input logic ice, input logic [31:0] iaddr, input int idly,
                           input logic dce, input logic dwe, input logic [3:0] dsel,
                           input logic [31:0] daddr, input logic [31:0] dwdata, input int ddly);
        acc_t exp_q[$];
        int   exp_stall = 0, exp_req = 0, exp_err = 0;
        int   stalls = 0, reqs = 0, err0;
        bit   ok;
        if (dce) begin
            ok = (ddly < TO);
            exp_q.push_back('{daddr, dwe, dsel, dwdata});
            dly_q.push_back(ddly);
            exp_req   += ok ? ddly + 1 : TO;
            exp_stall += 1 + (ok ? ddly + 1 : TO);
            if (!ok) exp_err++;
            if (dwe) begin
                if (ok) ref_mem[daddr] = merge(rd_ref(daddr), dwdata, dsel);
            end else begin
                exp_dm = ok ? rd_ref(daddr) : ERR;
            end
        end
        if (ice) begin
            ok = (idly < TO);
            exp_q.push_back('{iaddr, 1'b0, 4'hF, 32'd0});
            dly_q.push_back(idly);
            exp_req   += ok ? idly + 1 : TO;
            exp_stall += 1 + (ok ? idly + 1 : TO);
            if (!ok) exp_err++;
            exp_if = ok ? rd_ref(iaddr) : ERR;
        end
        err0 = bus_err_cnt;
        obs_q.delete();
        if_ce = ice; if_addr = iaddr;
        dm_ce = dce; dm_we = dwe; dm_sel = dsel; dm_addr = daddr; dm_wdata = dwdata;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (!stallreq) break;
            stalls++;
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("req_cycles", 32'(reqs), 32'(exp_req));
        chk("if_rdata", if_rdata, exp_if);
        chk("dm_rdata", dm_rdata, exp_dm);
        @(posedge clk); #1;
        chk("bus_err_pulses", 32'(bus_err_cnt - err0), 32'(exp_err));
        chk("access_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            chk("acc_addr", obs_q[k].addr, exp_q[k].addr);
            chk("acc_we", 32'(obs_q[k].we), 32'(exp_q[k].we));
            chk("acc_sel", 32'(obs_q[k].sel), 32'(exp_q[k].sel));
            if (exp_q[k].we) chk("acc_wdata", obs_q[k].wdata, exp_q[k].wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dl[6];
        dl = '{0, 0, 1, 2, 3, 6};
        rst = 1'b0;
        if_ce = 1'b1; if_addr = 32'h0; dm_ce = 1'b0; dm_we = 1'b0;
        dm_sel = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_sel", 32'(mem_sel), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        if_ce = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        bus_mem[32'h100] = 32'h3C01_0001;
        ref_mem[32'h100] = 32'h3C01_0001;
        // fetch only, immediate ack
        run_txn(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("fetch_word", if_rdata, 32'h3C01_0001);
        // simultaneous load and fetch
        run_txn(1, 32'h104, 0, 1, 0, 4'hF, 32'h200, 32'h0, 0);
        // store with three wait states, then fetch
        run_txn(1, 32'h108, 0, 1, 1, 4'b0011, 32'h208, 32'hDEAD_BEEF, 3);
        // fetch timeout
        run_txn(1, 32'h10C, 9, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        // back-to-back fetch-only pipeline cycles
        run_txn(1, 32'h110, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        run_txn(1, 32'h114, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        // store that times out, load back from the same word
        run_txn(0, 32'h0, 0, 1, 1, 4'hF, 32'h20C, 32'h1111_2222, 7);
        run_txn(0, 32'h0, 0, 1, 0, 4'hF, 32'h20C, 32'h0, 0);

        // reset during a data access
        dly_q.delete();
        dly_q.push_back(20);
        dm_ce = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h204; if_ce = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_stallreq", 32'(stallreq), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        exp_if = 32'd0; exp_dm = 32'd0;
        @(negedge clk);
        dly_q.delete();
        dly_q.push_back(0);
        obs_q.delete();
        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!stallreq) break;
        end
        chk("reissue_release", 32'(stallreq), 32'd0);
        exp_dm = rd_ref(32'h204);
        chk("reissue_dm_rdata", dm_rdata, exp_dm);
        @(posedge clk); #1;
        chk("reissue_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) chk("reissue_addr", obs_q[0].addr, 32'h204);
        dm_ce = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 60; t++) begin
            logic        ice, dce, dwe;
            logic [3:0]  dsel;
            logic [31:0] ia, da;
            ice  = 1'($urandom_range(0, 1));
            dce  = 1'($urandom_range(0, 1));
            dwe  = 1'($urandom_range(0, 1));
            dsel = 4'($urandom_range(0, 15));
            ia   = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            da   = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            run_txn(ice, ia, dl[$urandom_range(0, 5)], dce, dwe, dsel, da, $urandom,
                    dl[$urandom_range(0, 5)]);
        end

        chk("held_during_wait", 32'(hold_errs), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
